// File: rtl/pulse_inst_list_reader_pkg.sv
// Shared types and default sizing for the pulse instruction-list reader.
package pulse_inst_list_reader_pkg;

  localparam int DEF_GLB_COUNTER_WIDTH    = 24;
  localparam int DEF_DIRECTION_WIDTH      = 2;
  localparam int DEF_INST_LIST_ADDR_WIDTH = 5;
  localparam int DEF_INST_LIST_DATA_WIDTH = DEF_GLB_COUNTER_WIDTH + DEF_DIRECTION_WIDTH;

  // Reader sequencing states; each entry walks FETCH -> LOAD -> WAIT -> ISSUE.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_ISSUE = 3'd4
  } rdr_state_t;

endpackage

// File: rtl/pulse_due_compare.sv
// Wrap-safe "is it time yet" test between the global counter and an entry's
// start time. Valid while the two are within half the counter range.
module pulse_due_compare #(
  parameter int WIDTH = 24
) (
  input  logic [WIDTH-1:0] i_glb_counter,
  input  logic [WIDTH-1:0] i_start_time,
  output logic             o_due,
  output logic             o_late
);

  logic [WIDTH-1:0] w_diff;

  // Modular difference: a non-negative result means the start time has been reached.
  always_comb begin
    w_diff = i_glb_counter - i_start_time;
    o_due  = ~w_diff[WIDTH-1];
    o_late = |w_diff;
  end

endmodule

// File: rtl/pulse_inst_list_reader.sv
// Read side of the per-qubit pulse instruction list: tracks occupancy from the
// writer's commit strobe, fetches entries in order, waits for each start time
// and hands the pulse to the generator over valid/ready.
//
//   state  | meaning
//   IDLE   | list empty, waiting for an entry
//   FETCH  | read strobe to the list memory (one cycle)
//   LOAD   | read data returned, capture start time and direction
//   WAIT   | hold entry until the global counter reaches its start time
//   ISSUE  | pulse_valid high until the generator accepts it
module pulse_inst_list_reader
  import pulse_inst_list_reader_pkg::*;
#(
  parameter int GLB_COUNTER_WIDTH    = DEF_GLB_COUNTER_WIDTH,
  parameter int INST_LIST_ADDR_WIDTH = DEF_INST_LIST_ADDR_WIDTH,
  parameter int INST_LIST_DATA_WIDTH = DEF_INST_LIST_DATA_WIDTH,
  parameter int DIRECTION_WIDTH      = DEF_DIRECTION_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [GLB_COUNTER_WIDTH-1:0]    glb_counter_in,
  input  logic                            inst_list_wr_en,
  output logic                            inst_list_rd_en,
  output logic [INST_LIST_ADDR_WIDTH-1:0] inst_list_rd_addr,
  input  logic [INST_LIST_DATA_WIDTH-1:0] inst_list_rd_data,
  output logic                            pulse_valid,
  input  logic                            pulse_ready,
  output logic [DIRECTION_WIDTH-1:0]      pulse_direction,
  output logic                            pulse_late,
  output logic                            overflow
);

  localparam int CNT_W = INST_LIST_ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(2 ** INST_LIST_ADDR_WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [INST_LIST_ADDR_WIDTH-1:0] PTR_ONE = INST_LIST_ADDR_WIDTH'(1);

  rdr_state_t r_state;
  rdr_state_t w_state_nxt;

  logic [INST_LIST_ADDR_WIDTH-1:0] r_rd_ptr;
  logic [CNT_W-1:0]                r_count;
  logic                            r_overflow;

  logic [GLB_COUNTER_WIDTH-1:0]    r_start_time;
  logic [DIRECTION_WIDTH-1:0]      r_dir;

  logic                            r_pulse_valid;
  logic [DIRECTION_WIDTH-1:0]      r_pulse_direction;
  logic                            r_pulse_late;
  logic                            w_pulse_valid_nxt;
  logic [DIRECTION_WIDTH-1:0]      w_pulse_direction_nxt;
  logic                            w_pulse_late_nxt;

  logic w_fetch;
  logic w_full;
  logic w_not_empty;
  logic w_due;
  logic w_late;

  assign w_fetch     = (r_state == ST_FETCH);
  assign w_full      = (r_count == DEPTH);
  assign w_not_empty = (r_count != '0);

  assign inst_list_rd_en   = w_fetch;
  assign inst_list_rd_addr = r_rd_ptr;
  assign pulse_valid       = r_pulse_valid;
  assign pulse_direction   = r_pulse_direction;
  assign pulse_late        = r_pulse_late;
  assign overflow          = r_overflow;

  pulse_due_compare #(
    .WIDTH (GLB_COUNTER_WIDTH)
  ) u_due_compare (
    .i_glb_counter (glb_counter_in),
    .i_start_time  (r_start_time),
    .o_due         (w_due),
    .o_late        (w_late)
  );

  // Occupancy tracking: writer commits add, fetches remove; a commit into a
  // full list is dropped and latched as overflow until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      case ({inst_list_wr_en, w_fetch})
        2'b10: begin
          if (w_full) begin
            r_overflow <= 1'b1;
          end else begin
            r_count <= r_count + CNT_ONE;
          end
        end
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Read pointer advances once per fetch and wraps naturally at the list depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
    end else if (w_fetch) begin
      r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // Capture the fetched entry the cycle its read data is valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_start_time <= '0;
      r_dir        <= '0;
    end else if (r_state == ST_LOAD) begin
      r_start_time <= inst_list_rd_data[INST_LIST_DATA_WIDTH-1:DIRECTION_WIDTH];
      r_dir        <= inst_list_rd_data[DIRECTION_WIDTH-1:0];
    end
  end

  // State and registered pulse outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state           <= ST_IDLE;
      r_pulse_valid     <= 1'b0;
      r_pulse_direction <= '0;
      r_pulse_late      <= 1'b0;
    end else begin
      r_state           <= w_state_nxt;
      r_pulse_valid     <= w_pulse_valid_nxt;
      r_pulse_direction <= w_pulse_direction_nxt;
      r_pulse_late      <= w_pulse_late_nxt;
    end
  end

  // Next state and pulse output values; outputs hold unless a transition changes them.
  always_comb begin
    w_state_nxt           = r_state;
    w_pulse_valid_nxt     = r_pulse_valid;
    w_pulse_direction_nxt = r_pulse_direction;
    w_pulse_late_nxt      = r_pulse_late;
    case (r_state)
      ST_IDLE: begin
        if (w_not_empty) begin
          w_state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (w_due) begin
          w_pulse_valid_nxt     = 1'b1;
          w_pulse_direction_nxt = r_dir;
          w_pulse_late_nxt      = w_late;
          w_state_nxt           = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (r_pulse_valid && pulse_ready) begin
          w_pulse_valid_nxt = 1'b0;
          w_state_nxt       = w_not_empty ? ST_FETCH : ST_IDLE;
        end
      end
      default: begin
        w_state_nxt       = ST_IDLE;
        w_pulse_valid_nxt = 1'b0;
      end
    endcase
  end

endmodule
